// File: rtl/mips_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and its byte packer.
package mips_imem_loader_pkg;

  localparam int Data_Width     = 32;
  localparam int Byte_Width     = 8;
  localparam int Bytes_Per_Word = Data_Width / Byte_Width;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/mips_byte_packer.sv
// Big-endian byte-to-word packer: shifts bytes in MSB-first and flags the byte that completes a word.
module mips_byte_packer
  import mips_imem_loader_pkg::*;
#(
  parameter int Word_Width = Data_Width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  byte_en_i,
  input  logic [Byte_Width-1:0] byte_i,
  output logic [Word_Width-1:0] word_o,
  output logic                  word_valid_o
);

  localparam int Per_Word = Word_Width / Byte_Width;
  localparam int Idx_W    = (Per_Word > 1) ? $clog2(Per_Word) : 1;
  localparam logic [Idx_W-1:0] Last_Idx = Idx_W'(Per_Word - 1);

  logic [Word_Width-1:0] word_q, word_d;
  logic [Idx_W-1:0]      idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (byte_en_i) begin
      // Older bytes move toward the MSB, so the first byte ends in the top lane.
      word_d = (word_q << Byte_Width) | Word_Width'(byte_i);
      idx_d  = (idx_q == Last_Idx) ? '0 : idx_q + Idx_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_en_i && !clear_i && (idx_q == Last_Idx);

endmodule

// File: rtl/mips_imem_loader.sv
// Streams a byte-wise program image into instruction memory and holds the core in reset until it is complete.
// Optional trailing checksum byte: define MIPS_IMEM_LOADER_CHECKSUM_EN.
module mips_imem_loader #(
  parameter int Data_Width = mips_imem_loader_pkg::Data_Width,
  parameter int Addr_Width = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [Addr_Width:0]   num_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_wen,
  output logic [Addr_Width-1:0] imem_waddr,
  output logic [Data_Width-1:0] imem_wdata,
  output logic                  cpu_rst_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  import mips_imem_loader_pkg::*;

  localparam logic [Addr_Width:0] Capacity  = {1'b1, {Addr_Width{1'b0}}};
  localparam logic [Addr_Width:0] Words_One = (Addr_Width+1)'(1);

  loader_state_t         state_q, state_d;
  logic [Addr_Width-1:0] addr_q, addr_d;
  logic [Addr_Width:0]   words_left_q, words_left_d;

  logic                  xfer;
  logic                  len_ok;
  logic                  start_ok;
  logic                  pk_en;
  logic                  word_done;
  logic [Data_Width-1:0] word;

  assign xfer   = byte_valid && byte_ready;
  assign len_ok = (num_words != '0) && (num_words <= Capacity);
  assign pk_en  = xfer && (state_q == LOAD);

  mips_byte_packer #(
    .Word_Width (Data_Width)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (start_ok),
    .byte_en_i    (pk_en),
    .byte_i       (byte_data),
    .word_o       (word),
    .word_valid_o (word_done)
  );

`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_ok) begin
      sum_d = '0;
    end else if (pk_en) begin
      sum_d = sum_q + byte_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    start_ok     = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          if (len_ok) begin
            start_ok     = 1'b1;
            state_d      = LOAD;
            addr_d       = '0;
            words_left_d = num_words;
          end else begin
            state_d = ERR;
          end
        end
      end
      LOAD: begin
        if (word_done) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        // After the final word at the top address this wraps to 0, but it is never used again.
        addr_d       = addr_q + Addr_Width'(1);
        words_left_d = words_left_q - Words_One;
        if (words_left_q == Words_One) begin
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = LOAD;
        end
      end
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          state_d = (byte_data == sum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
    end
  end

  always_comb begin
    byte_ready   = (state_q == LOAD);
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    byte_ready   = (state_q == LOAD) || (state_q == CHECK);
`endif
    imem_wen     = (state_q == WRITE);
    busy         = (state_q == LOAD) || (state_q == WRITE);
    done         = (state_q == DONE);
    err          = (state_q == ERR);
    cpu_rst_hold = (state_q != DONE);
  end

  assign imem_waddr = addr_q;
  assign imem_wdata = word;

endmodule

// File: tb/tb_mips_imem_loader.sv
// Randomized bench for mips_imem_loader against an image-level reference model.
module tb_mips_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_wen;
  logic [9:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_hold;
  logic        busy;
  logic        done;
  logic        err;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int last_wen_cyc = 0;
  int done_cyc     = 0;

  logic [7:0]  img[$];
  int          obs_addr[$];
  logic [31:0] obs_data[$];

  mips_imem_loader #(
    .Data_Width (32),
    .Addr_Width (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_words    (num_words),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_wen     (imem_wen),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_hold (cpu_rst_hold),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_wen === 1'b1) begin
      obs_addr.push_back(int'(imem_waddr));
      obs_data.push_back(imem_wdata);
      last_wen_cyc = cyc;
      check_eq("ready_low_in_write", byte_ready, 0);
    end
  end

  function automatic logic [7:0] img_sum();
    logic [7:0] s = 8'h00;
    foreach (img[i]) s += img[i];
    return s;
  endfunction

  task automatic rand_img(input int nw);
    img.delete();
    for (int i = 0; i < 4 * nw; i++) img.push_back(8'($urandom));
  endtask

  // gap_mode: 0 always valid, 1 toggle 1-0-1, 2 random gaps.
  task automatic run_load(input int nw, input int gap_mode, input int start_at,
                          input int abort_at, input logic [7:0] extra);
    int   k, total, budget;
    bit   v, acc, toggle, pulsed, ok_exp;
    logic [31:0] exp_word;
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    start     = 1'b1;
    num_words = 11'(nw);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("hold_after_start", cpu_rst_hold, 1);
    check_eq("err_after_start", err, 0);
    check_eq("done_after_start", done, 0);
    total = img.size();
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    total++;
`endif
    k = 0; budget = 0; toggle = 1'b1; pulsed = 1'b0;
    while (k < total && k != abort_at && budget < 20 * total + 50) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       begin v = toggle; toggle = !toggle; end
        default: v = ($urandom_range(99) >= 30);
      endcase
      byte_valid = v;
      byte_data  = (k < img.size()) ? img[k] : extra;
      if (k == start_at && !pulsed) begin
        start     = 1'b1;
        num_words = 11'($urandom);
        pulsed    = 1'b1;
      end
      acc = v && byte_ready;
      @(negedge clk);
      start = 1'b0;
      if (acc) k++;
      budget++;
    end
    byte_valid = 1'b0;
    if (k == abort_at) return;
    check_eq("stream_complete", k, total);
    budget = 0;
    while (!(done || err) && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    done_cyc = cyc;
    check_eq("finish_in_time", budget < 20, 1);
    check_eq("wen_count", obs_addr.size(), nw);
    for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
      exp_word = {img[4*i], img[4*i+1], img[4*i+2], img[4*i+3]};
      check_eq("waddr", obs_addr[i], i);
      check_eq("wdata", obs_data[i], exp_word);
    end
    ok_exp = 1'b1;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    ok_exp = (extra == img_sum());
`else
    check_eq("hold_fall_latency", done_cyc - last_wen_cyc, 1);
`endif
    check_eq("done_final", done, ok_exp);
    check_eq("err_final", err, !ok_exp);
    check_eq("hold_final", cpu_rst_hold, !ok_exp);
    check_eq("busy_final", busy, 0);
    check_eq("ready_final", byte_ready, 0);
  endtask

  task automatic run_bad(input int nw);
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    start     = 1'b1;
    num_words = 11'(nw);
    @(negedge clk);
    start = 1'b0;
    check_eq("bad_err", err, 1);
    check_eq("bad_hold", cpu_rst_hold, 1);
    check_eq("bad_done", done, 0);
    check_eq("bad_busy", busy, 0);
    check_eq("bad_ready", byte_ready, 0);
    @(negedge clk);
    check_eq("bad_no_wen", obs_addr.size(), 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; num_words = '0; byte_valid = 1'b0; byte_data = '0;
    #1 rst = 1'b1;
    #1;
    check_eq("rst_ready", byte_ready, 0);
    check_eq("rst_wen", imem_wen, 0);
    check_eq("rst_waddr", imem_waddr, 0);
    check_eq("rst_wdata", imem_wdata, 0);
    check_eq("rst_hold", cpu_rst_hold, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    run_load(2, 0, -1, -1, 8'h35);
    run_load(2, 1, -1, -1, 8'h35);

    run_bad(0);
    run_bad(1025);
    run_bad(1025 + $urandom_range(1022));

    rand_img(3);
    run_load(3, 2, -1, -1, img_sum());

`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08};
    run_load(2, 0, -1, -1, 8'h36);
    run_load(2, 2, -1, -1, 8'h35);
`endif

    rand_img(2);
    run_load(2, 0, -1, 6, 8'h00);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_ready", byte_ready, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_hold", cpu_rst_hold, 1);
    check_eq("midrst_waddr", imem_waddr, 0);
    check_eq("midrst_wdata", imem_wdata, 0);
    check_eq("midrst_wen", imem_wen, 0);
    @(negedge clk);
    rst = 1'b0;
    rand_img(1);
    run_load(1, 0, -1, -1, img_sum());

    rand_img(4);
    run_load(4, 2, 5, -1, img_sum());
    rand_img(2);
    run_load(2, 2, 9, -1, img_sum());

    rand_img(1024);
    run_load(1024, 0, -1, -1, img_sum());

    for (int r = 0; r < 3; r++) begin
      int nw;
      nw = $urandom_range(1, 8);
      rand_img(nw);
      run_load(nw, 2, -1, -1, img_sum());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
